// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector, fetch FSM states and
// the prefetch buffer entry layout.
package cpu_pkg;

    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 32;
    localparam int IMEM_ADDR_W = 10;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HALTED,
        ST_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush overrides push and pop, and a
// push alongside a pop is accepted even when full.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  fetch_entry_t          din,
    output fetch_entry_t          head,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC and fetch FSM, pushes memory words
// into the prefetch FIFO and presents the head to decode over valid/ready.
module instr_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               fault
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    fetch_entry_t      head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              redir;
    logic              misaligned;
    logic              pop;
    logic              push;

    // Redirects are ignored once faulted; the FIFO is already empty there.
    assign redir       = redirect_valid && (state != ST_FAULT);
    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign instr_valid = !empty && (state != ST_FAULT);
    assign pop         = instr_valid && instr_ready;
    assign push        = (state == ST_FETCH) && !halt && !redirect_valid && (!full || pop);

    assign imem_pc   = fetch_pc;
    assign instr_out = instr_valid ? head.instr : '0;
    assign instr_pc  = instr_valid ? head.pc    : '0;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   ('{pc: fetch_pc, instr: imem_instr}),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            fetch_pc <= RESET_PC;
            fault    <= 1'b0;
        end else if (redir && misaligned) begin
            state <= ST_FAULT;
            fault <= 1'b1;
        end else begin
            if (redir) begin
                fetch_pc <= redirect_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            case (state)
                ST_FETCH:  if (halt)  state <= ST_HALTED;
                ST_HALTED: if (!halt) state <= ST_FETCH;
                default:   state <= state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((empty == (count == '0)) && (full == (count == CNT_W'(DEPTH))));
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_instr_fetch_ctrl;
    import cpu_pkg::*;

    localparam int                DEPTH    = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
    localparam int                MEM_WORDS = 2 ** (IMEM_ADDR_W - 2);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ADDR_W-1:0]  imem_pc;
    logic [INSTR_W-1:0] imem_instr;
    logic               halt = 1'b0;
    logic               redirect_valid = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;
    logic               instr_valid;
    logic               instr_ready = 1'b1;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               fault;

    logic [31:0] mem [MEM_WORDS];
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_pc[IMEM_ADDR_W-1:2]];

    instr_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fault          (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered PCs in a queue, the fetch address, whether halt
    // was seen at the last edge (fetching resumes one edge after it drops), and
    // the sticky fault.
    logic [31:0] m_q [$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_halted = 1'b0;
    bit          m_fault = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_pc     = RESET_PC;
            m_halted = 1'b0;
            m_fault  = 1'b0;
        end else if (!m_fault) begin
            if (redirect_valid) begin
                m_q.delete();
                if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
                else                            m_pc = redirect_pc;
            end else begin
                if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
                if (!m_halted && !halt && m_q.size() < DEPTH) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_halted = halt;
        end
    end

    logic        exp_valid;
    logic [31:0] exp_pc;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_valid = (m_q.size() > 0) && !m_fault;
            exp_pc    = exp_valid ? m_q[0] : 32'h0;
            check("model_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
            check("model_instr_pc", instr_pc, exp_pc);
            check("model_instr_out", instr_out, exp_valid ? mem[exp_pc[IMEM_ADDR_W-1:2]] : 32'h0);
            check("model_imem_pc", imem_pc, m_pc);
            check("model_fault", {31'b0, fault}, {31'b0, m_fault});
        end
    end

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        next();
        next();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;

        // In-order delivery from reset, one per cycle.
        instr_ready = 1'b1;
        rst = 1'b1;
        next();
        chk_en = 1'b1;
        do_reset();
        check("reset_imem_pc", imem_pc, 32'h0);
        check("reset_valid", {31'b0, instr_valid}, 32'h0);
        check("reset_instr_out", instr_out, 32'h0);
        check("reset_fault", {31'b0, fault}, 32'h0);
        next();
        check("c1_valid", {31'b0, instr_valid}, 32'h1);
        check("c1_pc", instr_pc, 32'h0);
        check("c1_instr", instr_out, 32'h1111_1111);
        next();
        check("c2_pc", instr_pc, 32'h4);
        check("c2_instr", instr_out, 32'h2222_2222);
        next();
        check("c3_pc", instr_pc, 32'h8);
        check("c3_instr", instr_out, 32'h3333_3333);

        // Backpressure: FIFO fills, fetch address holds, release without gaps.
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) check("bp_imem_hold", imem_pc, 32'h8);
            next();
        end
        instr_ready = 1'b1;
        check("bp_rel0", instr_pc, 32'h0);
        next();
        check("bp_rel1", instr_pc, 32'h4);
        next();
        check("bp_rel2", instr_pc, 32'h8);

        // Redirect while full with a dequeue in the same cycle.
        do_reset();
        instr_ready = 1'b0;
        next(); next(); next();
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        next();
        redirect_valid = 1'b0;
        check("redir_valid_low", {31'b0, instr_valid}, 32'h0);
        check("redir_imem_pc", imem_pc, 32'h40);
        next();
        check("redir_head", instr_pc, 32'h40);
        next();
        check("redir_next", instr_pc, 32'h44);

        // Misaligned redirect: sticky fault, later redirects ignored.
        do_reset();
        next(); next();
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        next();
        redirect_valid = 1'b0;
        check("mis_fault", {31'b0, fault}, 32'h1);
        check("mis_valid", {31'b0, instr_valid}, 32'h0);
        check("mis_pc_hold", imem_pc, 32'h8);
        next();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        next();
        redirect_valid = 1'b0;
        next();
        check("mis_ignore_pc", imem_pc, 32'h8);
        check("mis_still_fault", {31'b0, fault}, 32'h1);
        check("mis_still_invalid", {31'b0, instr_valid}, 32'h0);
        do_reset();
        check("mis_rst_fault", {31'b0, fault}, 32'h0);
        check("mis_rst_pc", imem_pc, RESET_PC);
        next();
        check("mis_rst_restart", instr_pc, 32'h0);

        // Halt at PC 0x10: drain, hold, resume at 0x10.
        do_reset();
        next(); next(); next(); next();
        check("halt_start_pc", imem_pc, 32'h10);
        check("halt_head", instr_pc, 32'hC);
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("halt_imem_hold", imem_pc, 32'h10);
            next();
        end
        halt = 1'b0;
        for (int i = 0; i < 6 && !instr_valid; i++) next();
        check("halt_resume_valid", {31'b0, instr_valid}, 32'h1);
        check("halt_resume_pc", instr_pc, 32'h10);

        // Wrap across the top of the address space, then a mid-stream reset.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        next();
        redirect_valid = 1'b0;
        check("wrap_imem_pc", imem_pc, 32'hFFFF_FFF8);
        next();
        check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        next();
        check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        next();
        check("wrap_pc2", instr_pc, 32'h0000_0000);
        check("wrap_instr2", instr_out, 32'h1111_1111);
        instr_ready = 1'b0;
        next(); next();
        check("full_before_rst", {31'b0, instr_valid}, 32'h1);
        rst = 1'b1;
        next();
        rst = 1'b0;
        check("rst_flush_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_flush_pc", imem_pc, RESET_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            rst = ($urandom_range(0, 99) == 0);
            next();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        next();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch controller that sequences the byte-addressed instruction memory. It owns the program counter, drives the memory's 32-bit `pc` input, and captures the combinationally returned little-endian word into a small prefetch FIFO. It then hands instructions to decode over a valid/ready handshake. It sits between `instruction_block` and the decode stage, and accepts branch/jump redirects from execute.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `DEPTH`, 2: prefetch FIFO entries; power of two, ≥2.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `imem_pc`  out  32: address to `instruction_block`; memory uses bits [9:0].
- `imem_instr`  in  32: word returned combinationally for `imem_pc` in the same cycle.
- `halt`  in  1: level; while high, no new fetches; buffered entries still drain.
- `redirect_valid`  in  1: one-cycle pulse; flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: redirect target.
- `instr_valid`  out  1: FIFO head holds a valid instruction.
- `instr_ready`  in  1: decode accepts the head this cycle.
- `instr_out`  out  32: head instruction word.
- `instr_pc`  out  32: PC of the head instruction.
- `fault`  out  1: sticky misaligned-redirect indicator.

## Operation
- FSM states: FETCH, HALTED, FAULT. Reset enters FETCH.
- FETCH → HALTED when `halt`=1. HALTED → FETCH when `halt`=0.
- Any state except FAULT → FAULT on `redirect_valid` with `redirect_pc[1:0]`≠0.
- FAULT exits only on `rst`.
- `imem_pc` always equals `fetch_pc`.
- Enqueue condition: state FETCH, `halt`=0, no redirect, and (count<DEPTH or dequeue this cycle).
- On enqueue, push {`fetch_pc`, `imem_instr`} and set `fetch_pc` += 4.
- `fetch_pc` is a full 32-bit increment with natural wrap (FFFF_FFFC→0000_0000). Memory aliasing via [9:0] is the memory's concern.
- Dequeue occurs when `instr_valid` && `instr_ready`.
- Aligned redirect: in the same edge, FIFO count→0 and `fetch_pc`←`redirect_pc`. No enqueue or dequeue is recorded that edge; a concurrent dequeue is dropped.
- Redirect has priority over `halt`. The PC is updated even while halted, but fetching stays stopped.
- Misaligned redirect: flush the FIFO, hold `fetch_pc`, set `fault`. `instr_valid` stays 0 until reset.
- A redirect while in FAULT is ignored.
- Outputs `instr_out` and `instr_pc` are don't-care when `instr_valid`=0. The bench must drive them to 0 for determinism.

## Timing
- Reset values: `fetch_pc`/`imem_pc`=RESET_PC, FIFO count=0, `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `fault`=0, state FETCH.
- Cycle 0 is the first cycle with `rst`=0. `imem_pc`=RESET_PC and the entry is captured at the end of cycle 0. `instr_valid`=1 in cycle 1.
- Fetch-to-output latency is 1 cycle.
- With `instr_ready` held high, throughput is one instruction per cycle.
- Redirect sampled at edge k:
  - cycle k+1: `imem_pc`=target, `instr_valid`=0.
  - cycle k+2: `instr_valid`=1 with `instr_pc`=target.
- FIFO full with no dequeue: `fetch_pc` holds, and the same address is re-presented until space frees.
- `halt` rising at edge k: no enqueue at edge k. Previously buffered entries drain normally.
- `rst` mid-operation overrides everything, including an active redirect, FAULT and a full FIFO.

## Structure
- Shared package `cpu_pkg`: `INSTR_W`=32, `ADDR_W`=32, `IMEM_ADDR_W`=10, default reset vector, and the fetch FSM state enum.
- Sub-module `fetch_fifo`:
  - synchronous DEPTH-entry FIFO of {pc, instr};
  - inputs: push, pop, flush;
  - outputs: count, full, empty;
  - simultaneous push and pop are legal when full;
  - flush overrides push and pop.
- Controller: FSM plus PC register only.

## Test plan
- Reset with RESET_PC=0, `instr_ready`=1, memory preloaded with words 0x11111111, 0x22222222, 0x33333333 at 0/4/8:
  - `instr_valid` rises in cycle 1;
  - outputs arrive in order with `instr_pc` 0, 4, 8 on consecutive cycles.
- Backpressure: `instr_ready`=0 for 5 cycles from cycle 0:
  - count saturates at 2 and `imem_pc` holds at 8;
  - on release, PCs 0, 4, 8 are delivered with no gap and no duplicate.
- Redirect to 0x40 while FIFO full and dequeue asserted:
  - next cycle `instr_valid`=0 and `imem_pc`=0x40;
  - the following cycle `instr_pc`=0x40;
  - neither of the stale entries ever appears.
- Misaligned redirect to 0x42:
  - `fault`=1 and `instr_valid`=0 permanently;
  - a later aligned redirect to 0x80 is ignored;
  - `rst` clears `fault` and restarts at RESET_PC.
- `halt` asserted at PC 0x10 for 4 cycles with ready high:
  - buffered entries drain and `imem_pc` stays 0x10;
  - after deassert, `instr_pc`=0x10 is next, with no skipped PC.
- Wrap: redirect to 0xFFFF_FFF8 gives `instr_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. `rst` pulsed mid-stream flushes all entries in one cycle.
